lsu_ctrl: RTL

Load/store sequencer between the execute stage and the data-memory port. It accepts one access per request and checks alignment. For a legal access it drives the memory bus with a req/ack handshake, generating byte enables and lane-replicated store data. For a load, it captures and sign- or zero-extends the returned lane into a held result. It also stalls the pipeline while the access is outstanding and aborts on misalignment or bus timeout.

---
 rtl/lsu_ctrl_if.sv | 21 ++
 rtl/lsu_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl_if.sv
// Data-memory bus between the load/store sequencer (master) and the memory port (slave).
// Requests use a req/ack handshake, and read data is valid in the cycle memAck is high.
interface lsu_ctrl_if;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [3:0]  memBe;
  logic [31:0] memWdata;
  logic [31:0] memRdata;
  logic        memAck;

  modport master (
    output memReq, memWe, memAddr, memBe, memWdata,
    input  memRdata, memAck
  );

  modport slave (
    input  memReq, memWe, memAddr, memBe, memWdata,
    output memRdata, memAck
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: checks alignment, runs one req/ack bus access with a timeout,
// and extends load data into a held result.
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              isStore,
  input  logic [2:0]        memSelect,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              alignErr,
  output logic              busErr,
  lsu_ctrl_if.master        mem
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] ERR    = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          store_q;
  logic [2:0]    sel_q;
  logic [1:0]    lane_q;

  logic          is_byte;
  logic          is_half;
  logic          misaligned;
  logic [3:0]    be_next;
  logic [31:0]   wdata_next;
  logic [7:0]    byte_lane;
  logic [15:0]   half_lane;
  logic [31:0]   load_val;

  assign busy = (state == IDLE && start) || state == ACCESS || state == ERR;

  // Size code 3 falls through to word handling everywhere.
  always_comb begin
    is_byte    = memSelect[1:0] == 2'd0;
    is_half    = memSelect[1:0] == 2'd1;
    misaligned = (is_half && addr[0]) || (!is_byte && !is_half && addr[1:0] != 2'b00);
    be_next    = 4'b1111;
    wdata_next = wdata;
    if (is_byte) begin
      be_next    = 4'b0001 << addr[1:0];
      wdata_next = {4{wdata[7:0]}};
    end else if (is_half) begin
      be_next    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_next = {2{wdata[15:0]}};
    end
  end

  // Lane choice follows the latched address, independent of which enables were driven.
  always_comb begin
    case (lane_q)
      2'd0:    byte_lane = mem.memRdata[7:0];
      2'd1:    byte_lane = mem.memRdata[15:8];
      2'd2:    byte_lane = mem.memRdata[23:16];
      default: byte_lane = mem.memRdata[31:24];
    endcase
    half_lane = lane_q[1] ? mem.memRdata[31:16] : mem.memRdata[15:0];
    case (sel_q[1:0])
      2'd0:    load_val = sel_q[2] ? {{24{byte_lane[7]}}, byte_lane} : {24'b0, byte_lane};
      2'd1:    load_val = sel_q[2] ? {{16{half_lane[15]}}, half_lane} : {16'b0, half_lane};
      default: load_val = mem.memRdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      store_q      <= 1'b0;
      sel_q        <= 3'b000;
      lane_q       <= 2'b00;
      done         <= 1'b0;
      alignErr     <= 1'b0;
      busErr       <= 1'b0;
      rdata        <= 32'b0;
      mem.memReq   <= 1'b0;
      mem.memWe    <= 1'b0;
      mem.memAddr  <= 32'b0;
      mem.memBe    <= 4'b0;
      mem.memWdata <= 32'b0;
    end else begin
      done     <= 1'b0;
      alignErr <= 1'b0;
      busErr   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            store_q <= isStore;
            sel_q   <= memSelect;
            lane_q  <= addr[1:0];
            count   <= '0;
            if (misaligned) begin
              state <= ERR;
            end else begin
              state        <= ACCESS;
              mem.memReq   <= 1'b1;
              mem.memWe    <= isStore;
              mem.memAddr  <= {addr[31:2], 2'b00};
              mem.memBe    <= be_next;
              mem.memWdata <= wdata_next;
            end
          end
        end
        ACCESS: begin
          // An ack in the final allowed cycle still completes normally.
          if (mem.memAck || count == LAST_COUNT) begin
            state        <= DONE;
            done         <= 1'b1;
            busErr       <= !mem.memAck;
            mem.memReq   <= 1'b0;
            mem.memWe    <= 1'b0;
            mem.memAddr  <= 32'b0;
            mem.memBe    <= 4'b0;
            mem.memWdata <= 32'b0;
            if (mem.memAck && !store_q) begin
              rdata <= load_val;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        ERR: begin
          state    <= DONE;
          done     <= 1'b1;
          alignErr <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
